id_ex_stage: RTL

- Decode/issue stage that drives the ALU's operand and control interface (a, b, 3-bit alu_control).
- Decodes an RV32I instruction word plus register-file read data into ALU operands, ALU control and memory/writeback/branch flags.
- Holds these in a one-entry pipeline register with valid/ready handshake and flush.
- Sits between the register-file read and the execute stage containing the ALU.

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/instr_decoder.sv | 42 ++++
 rtl/id_ex_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU codes, RV32I opcode/funct3 constants and the ID/EX payload type.
package riscv_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_e     alu_control;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic [31:0] store_data;
        logic [31:0] branch_target;
        logic [31:0] pc;
        logic        illegal;
    } id_ex_t;

    function automatic logic f3_alu_ok(input logic [2:0] f3);
        return f3 == F3_ADD || f3 == F3_AND || f3 == F3_OR || f3 == F3_SLT;
    endfunction

    function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
        return f3 == F3_AND ? ALU_AND : f3 == F3_OR ? ALU_OR : f3 == F3_SLT ? ALU_SLT : ALU_ADD;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational RV32I subset decode into ALU control, flags and immediate.
module instr_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output alu_op_e     alu_control,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        illegal,
    output logic        use_imm,
    output logic [31:0] imm
);
    logic [6:0] op;
    logic [2:0] f3;
    logic       r_ok, i_ok, lw, sw, beq;

    always_comb begin
        op          = instr[6:0];
        f3          = instr[14:12];
        r_ok        = op == OP_R && f3_alu_ok(f3);
        i_ok        = op == OP_I && f3_alu_ok(f3);
        lw          = op == OP_LOAD && f3 == F3_LW;
        sw          = op == OP_STORE && f3 == F3_SW;
        beq         = op == OP_BRANCH && f3 == F3_BEQ;
        alu_control = (beq || (r_ok && f3 == F3_ADD && instr[30])) ? ALU_SUB :
                      (r_ok || i_ok) ? f3_to_alu(f3) : ALU_ADD;
        illegal     = !(r_ok || i_ok || lw || sw || beq);
        rd          = (sw || beq) ? 5'd0 : instr[11:7];
        reg_write   = (r_ok || i_ok || lw) && instr[11:7] != 5'd0;
        mem_read    = lw;
        mem_write   = sw;
        branch      = beq;
        use_imm     = i_ok || lw || sw;
        // one immediate port: S-form for stores, B-form for branches, I-form otherwise
        imm         = sw  ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                      beq ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                            {{20{instr[31]}}, instr[31:20]};
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/issue stage feeding the ALU through a one-entry valid/ready register.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [2:0]       out_alu_control,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_branch,
    output logic [XLEN-1:0]  out_store_data,
    output logic [XLEN-1:0]  out_branch_target,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issue_count
);
    alu_op_e          dec_alu;
    logic [4:0]       dec_rd;
    logic             dec_rw, dec_mr, dec_mw, dec_br, dec_ill, dec_use_imm;
    logic [31:0]      dec_imm;
    id_ex_t           payload_d, payload_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, handshake;

    instr_decoder u_dec (
        .instr       (in_instr),
        .alu_control (dec_alu),
        .rd          (dec_rd),
        .reg_write   (dec_rw),
        .mem_read    (dec_mr),
        .mem_write   (dec_mw),
        .branch      (dec_br),
        .illegal     (dec_ill),
        .use_imm     (dec_use_imm),
        .imm         (dec_imm)
    );

    always_comb begin
        payload_d.a             = dec_ill ? '0 : rs1_data;
        payload_d.b             = dec_ill ? '0 : dec_use_imm ? dec_imm : rs2_data;
        payload_d.alu_control   = dec_alu;
        payload_d.rd            = dec_rd;
        payload_d.reg_write     = dec_rw;
        payload_d.mem_read      = dec_mr;
        payload_d.mem_write     = dec_mw;
        payload_d.branch        = dec_br;
        payload_d.store_data    = dec_mw ? rs2_data : '0;
        payload_d.branch_target = dec_br ? in_pc + dec_imm : '0;
        payload_d.pc            = in_pc;
        payload_d.illegal       = dec_ill;
    end

    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign handshake = valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            cnt_q     <= '0;
        end else begin
            if (handshake)
                cnt_q <= cnt_q + CNT_W'(1);
            // flush drops both the held entry and anything accepted this cycle
            if (flush)
                valid_q <= 1'b0;
            else if (accept) begin
                valid_q   <= 1'b1;
                payload_q <= payload_d;
            end else if (handshake)
                valid_q <= 1'b0;
        end
    end

    assign out_valid         = valid_q;
    assign out_a             = payload_q.a;
    assign out_b             = payload_q.b;
    assign out_alu_control   = payload_q.alu_control;
    assign out_rd            = payload_q.rd;
    assign out_reg_write     = payload_q.reg_write;
    assign out_mem_read      = payload_q.mem_read;
    assign out_mem_write     = payload_q.mem_write;
    assign out_branch        = payload_q.branch;
    assign out_store_data    = payload_q.store_data;
    assign out_branch_target = payload_q.branch_target;
    assign out_pc            = payload_q.pc;
    assign out_illegal       = payload_q.illegal;
    assign issue_count       = cnt_q;
endmodule
